control_unit: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 95 +++++++++
 rtl/ctrl_decode.sv | 140 ++++++++++++++
 rtl/control_unit.sv | 117 +++++++++++
 tb/tb_control_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, step states,
// opcode classes, the strobe bundle and the last-execute-step lookup.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_IMM, CLS_LDI, CLS_LD, CLS_ST, CLS_MULDIV, CLS_NEGNOT,
        CLS_BR, CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_HALT, CLS_NOP
    } op_class_t;

    typedef struct packed {
        logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out;
        logic inport_out, c_out, ba_out, r_out;
        logic mar_in, mdr_in, ir_in, pc_in, y_in, zlow_in, zhigh_in;
        logic hi_in, lo_in, con_in, outport_in, r_in;
        logic gra, grb, grc;
        logic inc_pc, read, ram_in;
        logic run;
    } strobes_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       cls = CLS_IMM;
            OP_LDI:                         cls = CLS_LDI;
            OP_LD:                          cls = CLS_LD;
            OP_ST:                          cls = CLS_ST;
            OP_MUL, OP_DIV:                 cls = CLS_MULDIV;
            OP_NEG, OP_NOT:                 cls = CLS_NEGNOT;
            OP_BR:                          cls = CLS_BR;
            OP_JR:                          cls = CLS_JR;
            OP_IN:                          cls = CLS_IN;
            OP_OUT:                         cls = CLS_OUT;
            OP_MFHI:                        cls = CLS_MFHI;
            OP_MFLO:                        cls = CLS_MFLO;
            OP_HALT:                        cls = CLS_HALT;
            default:                        cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    function automatic state_t last_step(input logic [4:0] op);
        state_t st;
        case (op_class(op))
            CLS_ALU, CLS_IMM, CLS_LDI: st = ST_T5;
            CLS_LD, CLS_ST:            st = ST_T7;
            CLS_MULDIV, CLS_BR:        st = ST_T6;
            CLS_NEGNOT:                st = ST_T4;
            default:                   st = ST_T3;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode: present step, opcode and CON_FF to the full
// control strobe bundle. Every strobe not named for a step stays low.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [4:0] opcode_i,
    input  logic       con_ff_i,
    output strobes_t   strobes_o
);

    op_class_t cls;

    assign cls = op_class(opcode_i);

    always_comb begin
        strobes_o     = '0;
        strobes_o.run = (state_i != ST_IDLE) && (state_i != ST_HALT);
        case (state_i)
            ST_T0: begin
                strobes_o.pc_out  = 1'b1;
                strobes_o.mar_in  = 1'b1;
                strobes_o.inc_pc  = 1'b1;
                strobes_o.zlow_in = 1'b1;
            end
            ST_T1: begin
                strobes_o.zlow_out = 1'b1;
                strobes_o.pc_in    = 1'b1;
                strobes_o.read     = 1'b1;
                strobes_o.mdr_in   = 1'b1;
            end
            ST_T2: begin
                strobes_o.mdr_out = 1'b1;
                strobes_o.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_ALU, CLS_IMM: begin
                        strobes_o.grb = 1'b1; strobes_o.r_out = 1'b1; strobes_o.y_in = 1'b1;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        strobes_o.grb = 1'b1; strobes_o.ba_out = 1'b1; strobes_o.y_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        strobes_o.gra = 1'b1; strobes_o.r_out = 1'b1; strobes_o.y_in = 1'b1;
                    end
                    CLS_NEGNOT: begin
                        strobes_o.grb = 1'b1; strobes_o.r_out = 1'b1; strobes_o.zlow_in = 1'b1;
                    end
                    CLS_BR: begin
                        strobes_o.gra = 1'b1; strobes_o.r_out = 1'b1; strobes_o.con_in = 1'b1;
                    end
                    CLS_JR: begin
                        strobes_o.gra = 1'b1; strobes_o.r_out = 1'b1; strobes_o.pc_in = 1'b1;
                    end
                    CLS_IN: begin
                        strobes_o.inport_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.r_in = 1'b1;
                    end
                    CLS_OUT: begin
                        strobes_o.gra = 1'b1; strobes_o.r_out = 1'b1; strobes_o.outport_in = 1'b1;
                    end
                    CLS_MFHI: begin
                        strobes_o.hi_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.r_in = 1'b1;
                    end
                    CLS_MFLO: begin
                        strobes_o.lo_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.r_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_ALU: begin
                        strobes_o.grc = 1'b1; strobes_o.r_out = 1'b1; strobes_o.zlow_in = 1'b1;
                    end
                    CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                        strobes_o.c_out = 1'b1; strobes_o.zlow_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        strobes_o.grb = 1'b1; strobes_o.r_out = 1'b1;
                        strobes_o.zhigh_in = 1'b1; strobes_o.zlow_in = 1'b1;
                    end
                    CLS_NEGNOT: begin
                        strobes_o.zlow_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.r_in = 1'b1;
                    end
                    CLS_BR: begin
                        strobes_o.pc_out = 1'b1; strobes_o.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_ALU, CLS_IMM, CLS_LDI: begin
                        strobes_o.zlow_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.r_in = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        strobes_o.zlow_out = 1'b1; strobes_o.mar_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        strobes_o.zlow_out = 1'b1; strobes_o.lo_in = 1'b1;
                    end
                    CLS_BR: begin
                        strobes_o.c_out = 1'b1; strobes_o.zlow_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CLS_LD: begin
                        strobes_o.read = 1'b1; strobes_o.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        strobes_o.gra = 1'b1; strobes_o.r_out = 1'b1; strobes_o.mdr_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        strobes_o.zhigh_out = 1'b1; strobes_o.hi_in = 1'b1;
                    end
                    CLS_BR: begin
                        // Taken branch loads PC from Z during the same step.
                        strobes_o.zlow_out = 1'b1; strobes_o.pc_in = con_ff_i;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CLS_LD: begin
                        strobes_o.mdr_out = 1'b1; strobes_o.gra = 1'b1; strobes_o.r_in = 1'b1;
                    end
                    CLS_ST: strobes_o.ram_in = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: state register and step sequencing only.
// Optional CU_STOP_EN adds a Stop input that diverts to HALT after an instruction.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       Clock,
    input  logic       Clear,
    input  logic [4:0] opcode,
    input  logic       CON_FF,
`ifdef CU_STOP_EN
    input  logic       Stop,
`endif
    output logic       PCout,
    output logic       ZHighout,
    output logic       ZLowout,
    output logic       MDRout,
    output logic       HIout,
    output logic       LOout,
    output logic       InPortOut,
    output logic       Cout,
    output logic       BAout,
    output logic       Rout,
    output logic       MARin,
    output logic       MDRin,
    output logic       IRin,
    output logic       PCin,
    output logic       Yin,
    output logic       ZLowIn,
    output logic       ZHighIn,
    output logic       HIin,
    output logic       LOin,
    output logic       CONin,
    output logic       OutPortIn,
    output logic       Rin,
    output logic       GRA,
    output logic       GRB,
    output logic       GRC,
    output logic       IncPC,
    output logic       Read,
    output logic       RAMin,
    output logic       Run,
    output logic [3:0] state_o
);

    state_t   state_q, state_d;
    strobes_t s;
    logic     stop_req;

`ifdef CU_STOP_EN
    assign stop_req = Stop;
`else
    assign stop_req = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_HALT: state_d = ST_HALT;
            default: begin
                if (state_q == last_step(opcode)) begin
                    if (opcode == OP_HALT || stop_req) state_d = ST_HALT;
                    else                              state_d = ST_T0;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
        endcase
    end

    ctrl_decode u_decode (
        .state_i   (state_q),
        .opcode_i  (opcode),
        .con_ff_i  (CON_FF),
        .strobes_o (s)
    );

    assign state_o   = state_q;
    assign PCout     = s.pc_out;
    assign ZHighout  = s.zhigh_out;
    assign ZLowout   = s.zlow_out;
    assign MDRout    = s.mdr_out;
    assign HIout     = s.hi_out;
    assign LOout     = s.lo_out;
    assign InPortOut = s.inport_out;
    assign Cout      = s.c_out;
    assign BAout     = s.ba_out;
    assign Rout      = s.r_out;
    assign MARin     = s.mar_in;
    assign MDRin     = s.mdr_in;
    assign IRin      = s.ir_in;
    assign PCin      = s.pc_in;
    assign Yin       = s.y_in;
    assign ZLowIn    = s.zlow_in;
    assign ZHighIn   = s.zhigh_in;
    assign HIin      = s.hi_in;
    assign LOin      = s.lo_in;
    assign CONin     = s.con_in;
    assign OutPortIn = s.outport_in;
    assign Rin       = s.r_in;
    assign GRA       = s.gra;
    assign GRB       = s.grb;
    assign GRC       = s.grc;
    assign IncPC     = s.inc_pc;
    assign Read      = s.read;
    assign RAMin     = s.ram_in;
    assign Run       = s.run;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction step lists written as strobe-name
// strings feed an expected queue; a negedge monitor compares every cycle.
module tb_control_unit;

    logic       Clock = 1'b0;
    logic       Clear = 1'b1;
    logic [4:0] opcode = 5'd0;
    logic       CON_FF = 1'b0;
`ifdef CU_STOP_EN
    logic       Stop = 1'b0;
`endif
    logic PCout, ZHighout, ZLowout, MDRout, HIout, LOout, InPortOut, Cout, BAout, Rout;
    logic MARin, MDRin, IRin, PCin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn, Rin;
    logic GRA, GRB, GRC, IncPC, Read, RAMin, Run;
    logic [3:0] state_o;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .opcode(opcode), .CON_FF(CON_FF),
`ifdef CU_STOP_EN
        .Stop(Stop),
`endif
        .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortOut(InPortOut), .Cout(Cout),
        .BAout(BAout), .Rout(Rout), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .PCin(PCin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin),
        .LOin(LOin), .CONin(CONin), .OutPortIn(OutPortIn), .Rin(Rin),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .IncPC(IncPC), .Read(Read),
        .RAMin(RAMin), .Run(Run), .state_o(state_o)
    );

    // ---------------- clock ----------------
    always #5 Clock = ~Clock;

    // ---------------- observed vector (bit i = names[i]) ----------------
    string names[29] = '{"PCout", "ZHighout", "ZLowout", "MDRout", "HIout", "LOout",
                         "InPortOut", "Cout", "BAout", "Rout",
                         "MARin", "MDRin", "IRin", "PCin", "Yin", "ZLowIn", "ZHighIn",
                         "HIin", "LOin", "CONin", "OutPortIn", "Rin",
                         "GRA", "GRB", "GRC", "IncPC", "Read", "RAMin", "Run"};
    logic [28:0] obs;
    assign obs = {Run, RAMin, Read, IncPC, GRC, GRB, GRA,
                  Rin, OutPortIn, CONin, LOin, HIin, ZHighIn, ZLowIn, Yin, PCin, IRin, MDRin, MARin,
                  Rout, BAout, Cout, InPortOut, LOout, HIout, MDRout, ZLowout, ZHighout, PCout};

    logic [28:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    string prog_q[$];

    function automatic logic [28:0] bit_of(string nm);
        logic [28:0] v = '0;
        for (int i = 0; i < 29; i++)
            if (names[i] == nm) v[i] = 1'b1;
        return v;
    endfunction

    // Parse a space-separated list of strobe names; active steps also raise Run.
    function automatic logic [28:0] vec(string s, bit active);
        logic [28:0] v = '0;
        string tok = "";
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s.substr(i, i) == " ") begin
                if (tok.len() > 0) v |= bit_of(tok);
                tok = "";
            end else begin
                tok = {tok, s.substr(i, i)};
            end
        end
        if (active) v |= bit_of("Run");
        return v;
    endfunction

    // Reference micro-program: one string per clock, fetch included.
    function automatic void build_prog(logic [4:0] op, bit con);
        prog_q.delete();
        prog_q.push_back("PCout MARin IncPC ZLowIn");
        prog_q.push_back("ZLowout PCin Read MDRin");
        prog_q.push_back("MDRout IRin");
        if (op >= 5'd3 && op <= 5'd10) begin
            prog_q.push_back("GRB Rout Yin"); prog_q.push_back("GRC Rout ZLowIn");
            prog_q.push_back("ZLowout GRA Rin");
        end else if (op >= 5'd12 && op <= 5'd14) begin
            prog_q.push_back("GRB Rout Yin"); prog_q.push_back("Cout ZLowIn");
            prog_q.push_back("ZLowout GRA Rin");
        end else if (op <= 5'd2) begin
            prog_q.push_back("GRB BAout Yin"); prog_q.push_back("Cout ZLowIn");
            if (op == 5'd1) prog_q.push_back("ZLowout GRA Rin");
            else begin
                prog_q.push_back("ZLowout MARin");
                if (op == 5'd0) begin
                    prog_q.push_back("Read MDRin"); prog_q.push_back("MDRout GRA Rin");
                end else begin
                    prog_q.push_back("GRA Rout MDRin"); prog_q.push_back("RAMin");
                end
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            prog_q.push_back("GRA Rout Yin"); prog_q.push_back("GRB Rout ZHighIn ZLowIn");
            prog_q.push_back("ZLowout LOin"); prog_q.push_back("ZHighout HIin");
        end else if (op == 5'd17 || op == 5'd18) begin
            prog_q.push_back("GRB Rout ZLowIn"); prog_q.push_back("ZLowout GRA Rin");
        end else if (op == 5'd19) begin
            prog_q.push_back("GRA Rout CONin"); prog_q.push_back("PCout Yin");
            prog_q.push_back("Cout ZLowIn");
            prog_q.push_back(con ? "ZLowout PCin" : "ZLowout");
        end else if (op == 5'd20) prog_q.push_back("GRA Rout PCin");
        else if (op == 5'd22) prog_q.push_back("InPortOut GRA Rin");
        else if (op == 5'd23) prog_q.push_back("GRA Rout OutPortIn");
        else if (op == 5'd24) prog_q.push_back("HIout GRA Rin");
        else if (op == 5'd25) prog_q.push_back("LOout GRA Rin");
        else prog_q.push_back("");
    endfunction

    // ---------------- driver ----------------
    // Push the expectation for the state entered at the next rising edge.
    task automatic cycle(logic [28:0] e);
        exp_q.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    // abort_at >= 0 raises Clear during that step index.
    task automatic run_instr(logic [4:0] op, bit con, int abort_at);
        build_prog(op, con);
        cycle(vec(prog_q[0], 1'b1));
        opcode = op;
        CON_FF = con;
        for (int i = 1; i < prog_q.size(); i++) begin
            cycle(vec(prog_q[i], 1'b1));
            if (i == abort_at) begin
                Clear = 1'b1;
                cycle('0);
                Clear = 1'b0;
                return;
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge Clock) begin
        logic [28:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL strobes t=%0t opcode=%b got=%b want=%b", $time, opcode, obs, e);
            end
            n_cmp++;
            if ($countones(obs[9:0]) > 1) begin
                n_bad++;
                $display("FAIL bus_onehot t=%0t got=%b want at most one", $time, obs[9:0]);
            end
        end
    end

    initial begin
        logic [4:0] op;
        // Reset for two edges: IDLE, everything low.
        cycle('0);
        cycle('0);
        Clear = 1'b0;
        run_instr(5'b01100, 1'b0, -1);   // addi
        run_instr(5'b00000, 1'b0, -1);   // ld
        run_instr(5'b10011, 1'b0, -1);   // br not taken
        run_instr(5'b10011, 1'b1, -1);   // br taken
        run_instr(5'b00010, 1'b0, 6);    // st aborted by Clear in T6
        run_instr(5'b00010, 1'b0, -1);   // st complete
        for (int k = 0; k < 40; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            run_instr(op, 1'($urandom_range(0, 1)), -1);
        end
        run_instr(5'b11011, 1'b0, -1);   // halt
        for (int k = 0; k < 20; k++) cycle('0);
        Clear = 1'b1;
        cycle('0);
        Clear = 1'b0;
        run_instr(5'b10100, 1'b0, -1);   // jr after recovery
        @(negedge Clock);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
